// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin share of one combinational ALU between two
// requesters, with registered operands and a one-deep response slot each.
//
// Ports:
//   clock, resetn              rising-edge clock, async active-low reset
//   reqN_valid/ready           request handshake (N = 0, 1)
//   reqN_opcode/shamt/a/b      request payload
//   respN_valid/ready          response slot handshake
//   respN_result/flags         captured result, flags {err, ovf, lt, ne}
//   alu_operandA/B, alu_opcode, alu_shiftamt   registered ALU inputs
//   alu_result, alu_isNotEqual, alu_isLessThan, alu_overflow   ALU outputs
//
// Build option: ALU_ARB_ILLEGAL_OP_EN - opcodes above LAST_LEGAL_OP are
// answered locally with result 0 and flags 4'b1000 instead of reaching the ALU.
module alu_share_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int LAST_LEGAL_OP = 5
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [4:0]            req0_opcode,
    input  logic [4:0]            req0_shamt,
    input  logic [DATA_WIDTH-1:0] req0_a,
    input  logic [DATA_WIDTH-1:0] req0_b,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [4:0]            req1_opcode,
    input  logic [4:0]            req1_shamt,
    input  logic [DATA_WIDTH-1:0] req1_a,
    input  logic [DATA_WIDTH-1:0] req1_b,
    output logic                  resp0_valid,
    input  logic                  resp0_ready,
    output logic [DATA_WIDTH-1:0] resp0_result,
    output logic [3:0]            resp0_flags,
    output logic                  resp1_valid,
    input  logic                  resp1_ready,
    output logic [DATA_WIDTH-1:0] resp1_result,
    output logic [3:0]            resp1_flags,
    output logic [DATA_WIDTH-1:0] alu_operandA,
    output logic [DATA_WIDTH-1:0] alu_operandB,
    output logic [4:0]            alu_opcode,
    output logic [4:0]            alu_shiftamt,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic                  alu_isNotEqual,
    input  logic                  alu_isLessThan,
    input  logic                  alu_overflow
);

    typedef enum logic {S_IDLE = 1'b0, S_EXEC = 1'b1} state_t;

    localparam logic [4:0] LP_LAST_OP = 5'(LAST_LEGAL_OP);

    state_t                r_state;
    logic                  r_last_grant;
    logic                  r_owner;
    logic [DATA_WIDTH-1:0] r_alu_a;
    logic [DATA_WIDTH-1:0] r_alu_b;
    logic [4:0]            r_alu_op;
    logic [4:0]            r_alu_sh;
    logic                  r_resp0_valid;
    logic                  r_resp1_valid;
    logic [DATA_WIDTH-1:0] r_resp0_result;
    logic [DATA_WIDTH-1:0] r_resp1_result;
    logic [3:0]            r_resp0_flags;
    logic [3:0]            r_resp1_flags;

    logic                  w_elig0;
    logic                  w_elig1;
    logic                  w_gnt0;
    logic                  w_gnt1;
    logic [DATA_WIDTH-1:0] w_sel_a;
    logic [DATA_WIDTH-1:0] w_sel_b;
    logic [4:0]            w_sel_op;
    logic [4:0]            w_sel_sh;
    logic                  w_op_over;
    logic                  w_illegal;
    logic [DATA_WIDTH-1:0] w_res;
    logic [3:0]            w_flags;

    // A full slot that drains this edge counts as free.
    assign w_elig0 = (r_state == S_IDLE) & req0_valid
                   & (~r_resp0_valid | resp0_ready);
    assign w_elig1 = (r_state == S_IDLE) & req1_valid
                   & (~r_resp1_valid | resp1_ready);

    // On a tie the requester that was not granted last wins.
    assign w_gnt0 = w_elig0 & (~w_elig1 | r_last_grant);
    assign w_gnt1 = w_elig1 & (~w_elig0 | ~r_last_grant);

    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;

    assign w_sel_a   = w_gnt1 ? req1_a      : req0_a;
    assign w_sel_b   = w_gnt1 ? req1_b      : req0_b;
    assign w_sel_op  = w_gnt1 ? req1_opcode : req0_opcode;
    assign w_sel_sh  = w_gnt1 ? req1_shamt  : req0_shamt;
    assign w_op_over = (w_sel_op > LP_LAST_OP);

`ifdef ALU_ARB_ILLEGAL_OP_EN
    logic r_illegal;

    assign w_illegal = w_op_over;
    assign w_res     = r_illegal ? '0 : alu_result;
    assign w_flags   = r_illegal ? 4'b1000
                     : {1'b0, alu_overflow, alu_isLessThan, alu_isNotEqual};

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_illegal <= 1'b0;
        end else if (w_gnt0 | w_gnt1) begin
            r_illegal <= w_illegal;
        end
    end
`else
    logic w_unused_op_over;

    assign w_unused_op_over = w_op_over;
    assign w_illegal        = 1'b0;
    assign w_res            = alu_result;
    assign w_flags          = {1'b0, alu_overflow, alu_isLessThan, alu_isNotEqual};
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state        <= S_IDLE;
            r_last_grant   <= 1'b1;
            r_owner        <= 1'b0;
            r_alu_a        <= '0;
            r_alu_b        <= '0;
            r_alu_op       <= '0;
            r_alu_sh       <= '0;
            r_resp0_valid  <= 1'b0;
            r_resp1_valid  <= 1'b0;
            r_resp0_result <= '0;
            r_resp1_result <= '0;
            r_resp0_flags  <= '0;
            r_resp1_flags  <= '0;
        end else begin
            if (r_resp0_valid & resp0_ready) r_resp0_valid <= 1'b0;
            if (r_resp1_valid & resp1_ready) r_resp1_valid <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_gnt0 | w_gnt1) begin
                        r_alu_a      <= w_sel_a;
                        r_alu_b      <= w_sel_b;
                        r_alu_op     <= w_illegal ? 5'd0 : w_sel_op;
                        r_alu_sh     <= w_sel_sh;
                        r_owner      <= w_gnt1;
                        r_last_grant <= w_gnt1;
                        r_state      <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    // Fill overrides a drain on the same edge.
                    if (r_owner) begin
                        r_resp1_valid  <= 1'b1;
                        r_resp1_result <= w_res;
                        r_resp1_flags  <= w_flags;
                    end else begin
                        r_resp0_valid  <= 1'b1;
                        r_resp0_result <= w_res;
                        r_resp0_flags  <= w_flags;
                    end
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign alu_operandA = r_alu_a;
    assign alu_operandB = r_alu_b;
    assign alu_opcode   = r_alu_op;
    assign alu_shiftamt = r_alu_sh;
    assign resp0_valid  = r_resp0_valid;
    assign resp1_valid  = r_resp1_valid;
    assign resp0_result = r_resp0_result;
    assign resp1_result = r_resp1_result;
    assign resp0_flags  = r_resp0_flags;
    assign resp1_flags  = r_resp1_flags;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed and random checks of alu_share_arbiter
// against an ALU stand-in and an arithmetic reference model.
module tb_alu_share_arbiter;
    localparam int DW = 32;

    logic          clock = 1'b0;
    logic          resetn;
    logic          req0_valid, req0_ready, req1_valid, req1_ready;
    logic [4:0]    req0_opcode, req0_shamt, req1_opcode, req1_shamt;
    logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
    logic          resp0_valid, resp0_ready, resp1_valid, resp1_ready;
    logic [DW-1:0] resp0_result, resp1_result;
    logic [3:0]    resp0_flags, resp1_flags;
    logic [DW-1:0] alu_operandA, alu_operandB, alu_result;
    logic [4:0]    alu_opcode, alu_shiftamt;
    logic          alu_isNotEqual, alu_isLessThan, alu_overflow;

    int          total = 0;
    int          bad   = 0;
    bit          model_last;
    logic [35:0] q0[$];
    logic [35:0] q1[$];

    always #5 clock = ~clock;

    alu_share_arbiter #(.DATA_WIDTH(DW), .LAST_LEGAL_OP(5)) dut (
        .clock(clock), .resetn(resetn),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_opcode(req0_opcode), .req0_shamt(req0_shamt),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_opcode(req1_opcode), .req1_shamt(req1_shamt),
        .req1_a(req1_a), .req1_b(req1_b),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
        .resp0_result(resp0_result), .resp0_flags(resp0_flags),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
        .resp1_result(resp1_result), .resp1_flags(resp1_flags),
        .alu_operandA(alu_operandA), .alu_operandB(alu_operandB),
        .alu_opcode(alu_opcode), .alu_shiftamt(alu_shiftamt),
        .alu_result(alu_result), .alu_isNotEqual(alu_isNotEqual),
        .alu_isLessThan(alu_isLessThan), .alu_overflow(alu_overflow)
    );

    // ALU stand-in: flags are only driven for subtract.
    always_comb begin
        alu_result     = '0;
        alu_isNotEqual = 1'b0;
        alu_isLessThan = 1'b0;
        alu_overflow   = 1'b0;
        case (alu_opcode)
            5'd0: alu_result = alu_operandA + alu_operandB;
            5'd1: begin
                alu_result     = alu_operandA - alu_operandB;
                alu_isNotEqual = alu_operandA != alu_operandB;
                alu_isLessThan = $signed(alu_operandA) < $signed(alu_operandB);
                alu_overflow   = (alu_operandA[31] ^ alu_operandB[31])
                               & (alu_result[31] ^ alu_operandA[31]);
            end
            5'd2: alu_result = alu_operandA & alu_operandB;
            5'd3: alu_result = alu_operandA | alu_operandB;
            5'd4: alu_result = alu_operandA << alu_shiftamt;
            5'd5: alu_result = $signed(alu_operandA) >>> alu_shiftamt;
            default: ;
        endcase
    end

    function automatic logic [35:0] ref_op(input logic [4:0] op, input logic [4:0] sh,
                                           input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, d;
        logic [31:0] r;
        logic [3:0]  f;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = '0;
        f  = '0;
        case (op)
            5'd0: r = a + b;
            5'd1: begin
                d    = sa - sb;
                r    = d[31:0];
                f[2] = (d > 64'sh7FFFFFFF) || (d < -64'sh80000000);
                f[1] = sa < sb;
                f[0] = a != b;
            end
            5'd2: r = a & b;
            5'd3: r = a | b;
            5'd4: r = a << sh;
            5'd5: begin
                d = sa >>> sh;
                r = d[31:0];
            end
            default: ;
        endcase
`ifdef ALU_ARB_ILLEGAL_OP_EN
        if (op > 5'd5) begin
            r = '0;
            f = 4'b1000;
        end
`endif
        return {f, r};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Lone request from requester n into a free slot, then drain that slot.
    task automatic single(input int n, input logic [4:0] op, input logic [4:0] sh,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] er, input logic [3:0] ef,
                          input string tag);
        logic [4:0] eop;
        eop = op;
`ifdef ALU_ARB_ILLEGAL_OP_EN
        if (op > 5'd5) eop = 5'd0;
`endif
        if (n == 0) begin
            req0_valid = 1'b1; req0_opcode = op; req0_shamt = sh;
            req0_a = a; req0_b = b;
        end else begin
            req1_valid = 1'b1; req1_opcode = op; req1_shamt = sh;
            req1_a = a; req1_b = b;
        end
        #1;
        chk({tag, "_grant"}, {req1_ready, req0_ready}, (n == 0) ? 2'b01 : 2'b10);
        @(posedge clock); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        model_last = n[0];
        chk({tag, "_exec"}, {req1_ready, req0_ready}, 2'b00);
        chk({tag, "_aluop"}, {alu_opcode, alu_shiftamt}, {eop, sh});
        chk({tag, "_aluab"}, {alu_operandA, alu_operandB}, {a, b});
        @(posedge clock); #1;
        chk({tag, "_valid"}, (n == 0) ? resp0_valid : resp1_valid, 1);
        chk({tag, "_res"}, (n == 0) ? resp0_result : resp1_result, er);
        chk({tag, "_flags"}, (n == 0) ? resp0_flags : resp1_flags, ef);
        if (n == 0) resp0_ready = 1'b1; else resp1_ready = 1'b1;
        @(posedge clock); #1;
        chk({tag, "_drain"}, (n == 0) ? resp0_valid : resp1_valid, 0);
        resp0_ready = 1'b0;
        resp1_ready = 1'b0;
    endtask

    initial begin
        logic [1:0] expg;
        int         g0, g1, lat0, lat1;
        bit         acc0, acc1, prev_acc, e0, e1;

        resetn = 1'b0;
        req0_valid = 0; req0_opcode = 0; req0_shamt = 0; req0_a = 0; req0_b = 0;
        req1_valid = 0; req1_opcode = 0; req1_shamt = 0; req1_a = 0; req1_b = 0;
        resp0_ready = 0; resp1_ready = 0;
        model_last = 1'b1;
        #2;
        chk("rst_ready", {req1_ready, req0_ready}, 0);
        chk("rst_valid", {resp1_valid, resp0_valid}, 0);
        chk("rst_res", {resp1_result, resp0_result}, 0);
        chk("rst_flags", {resp1_flags, resp0_flags}, 0);
        chk("rst_aluab", {alu_operandA, alu_operandB}, 0);
        chk("rst_aluop", {alu_opcode, alu_shiftamt}, 0);
        @(negedge clock); resetn = 1'b1;
        @(posedge clock); #1;

        single(0, 5'd0, 5'd0, 32'd7, 32'd5, 32'd12, 4'b0000, "t1_add");
        single(1, 5'd1, 5'd0, 32'd3, 32'd9, 32'hFFFFFFFA, 4'b0011, "t2_sub");
        single(1, 5'd1, 5'd0, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 4'b0101, "t2_ovf");
        single(0, 5'd4, 5'd31, 32'd1, 32'd0, 32'h80000000, 4'b0000, "t5_sll");
        single(1, 5'd5, 5'd4, 32'h80000000, 32'd0, 32'hF8000000, 4'b0000, "t5_sra");
        single(0, 5'd2, 5'd0, 32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00, 4'b0000, "t_and");

        // Both requesting back to back: alternate grants, one per 2 cycles.
        req0_valid = 1; req0_opcode = 0; req0_a = 1; req0_b = 2;
        req1_valid = 1; req1_opcode = 3; req1_a = 2; req1_b = 4;
        resp0_ready = 1; resp1_ready = 1;
        g0 = 0; g1 = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            expg = (i % 2 == 0) ? (model_last ? 2'b01 : 2'b10) : 2'b00;
            chk("t3_grant", {req1_ready, req0_ready}, expg);
            g0 += int'(req0_ready);
            g1 += int'(req1_ready);
            if (expg == 2'b01) model_last = 1'b0;
            if (expg == 2'b10) model_last = 1'b1;
            @(posedge clock); #1;
        end
        chk("t3_count", {g0[15:0], g1[15:0]}, {16'd2, 16'd2});
        req0_valid = 0; req1_valid = 0;
        repeat (2) begin @(posedge clock); #1; end
        chk("t3_idle", {resp1_valid, resp0_valid}, 0);
        resp0_ready = 0; resp1_ready = 0;

        // Full, stalled slot 0 must not block requester 1.
        req0_valid = 1; req0_opcode = 1; req0_a = 100; req0_b = 1;
        #1;
        chk("t4_fill_grant", {req1_ready, req0_ready}, 2'b01);
        @(posedge clock); #1;
        req0_valid = 0;
        model_last = 1'b0;
        @(posedge clock); #1;
        chk("t4_fill", {resp0_valid, resp0_result}, {1'b1, 32'd99});
        single(1, 5'd2, 5'd0, 32'hF0, 32'h3C, 32'h30, 4'b0000, "t4_b");
        req0_valid = 1; req0_opcode = 0; req0_a = 5; req0_b = 5;
        req1_valid = 1; req1_opcode = 3; req1_a = 1; req1_b = 2;
        #1;
        chk("t4_block", {req1_ready, req0_ready}, 2'b10);
        @(posedge clock); #1;
        req1_valid = 0;
        model_last = 1'b1;
        @(posedge clock); #1;
        chk("t4_r1", {resp1_valid, resp1_result}, {1'b1, 32'd3});
        chk("t4_hold", {resp0_valid, resp0_result, resp0_flags}, {1'b1, 32'd99, 4'b0001});
        req1_valid = 1; req1_opcode = 0; req1_a = 0; req1_b = 0;
        resp0_ready = 1;
        #1;
        chk("t4_release", {req1_ready, req0_ready}, 2'b01);
        @(posedge clock); #1;
        model_last = 1'b0;
        req0_valid = 0; req1_valid = 0; resp0_ready = 0;
        chk("t4_emptied", resp0_valid, 0);
        @(posedge clock); #1;
        chk("t4_refill", {resp0_valid, resp0_result}, {1'b1, 32'd10});
        resp0_ready = 1; resp1_ready = 1;
        @(posedge clock); #1;
        chk("t4_done", {resp1_valid, resp0_valid}, 0);
        resp0_ready = 0; resp1_ready = 0;

        // Reset in the middle of an operation.
        req0_valid = 1; req0_opcode = 0; req0_a = 1; req0_b = 1;
        @(posedge clock); #1;
        req0_valid = 0;
        resetn = 1'b0;
        #1;
        chk("t6_rst", {resp0_valid, alu_operandA}, 0);
        @(negedge clock); resetn = 1'b1;
        model_last = 1'b1;
        repeat (2) begin @(posedge clock); #1; end
        chk("t6_noresp", {resp1_valid, resp0_valid}, 0);
        req0_valid = 1; req0_opcode = 1; req0_a = 10; req0_b = 3;
        req1_valid = 1; req1_opcode = 2; req1_a = 1; req1_b = 1;
        #1;
        chk("t6_tie", {req1_ready, req0_ready}, 2'b01);
        @(posedge clock); #1;
        model_last = 1'b0;
        req0_valid = 0; req1_valid = 0;
        @(posedge clock); #1;
        chk("t6_res", {resp0_valid, resp0_result, resp0_flags}, {1'b1, 32'd7, 4'b0001});
        resp0_ready = 1;
        @(posedge clock); #1;
        resp0_ready = 0;

`ifdef ALU_ARB_ILLEGAL_OP_EN
        single(0, 5'd7, 5'd0, 32'd4, 32'd4, 32'd0, 4'b1000, "t6_illegal");
`else
        single(0, 5'd7, 5'd0, 32'd4, 32'd4, 32'd0, 4'b0000, "t6_passop");
`endif

        // Random traffic against the reference model.
        acc0 = 0; acc1 = 0; prev_acc = 0; lat0 = 0; lat1 = 0;
        for (int i = 0; i < 420; i++) begin
            if (req0_valid) begin
                if (acc0 || $urandom_range(0, 9) == 0) req0_valid = 0;
            end else if (i < 400 && $urandom_range(0, 2) == 0) begin
                req0_valid  = 1;
                req0_opcode = 5'($urandom_range(0, 5));
                req0_shamt  = 5'($urandom);
                req0_a      = $urandom;
                req0_b      = ($urandom_range(0, 3) == 0) ? req0_a : $urandom;
            end
            if (req1_valid) begin
                if (acc1 || $urandom_range(0, 9) == 0) req1_valid = 0;
            end else if (i < 400 && $urandom_range(0, 2) == 0) begin
                req1_valid  = 1;
                req1_opcode = 5'($urandom_range(0, 5));
                req1_shamt  = 5'($urandom);
                req1_a      = $urandom;
                req1_b      = ($urandom_range(0, 3) == 0) ? req1_a : $urandom;
            end
            resp0_ready = (i >= 400) || ($urandom_range(0, 3) != 0);
            resp1_ready = (i >= 400) || ($urandom_range(0, 3) != 0);
            #1;
            if (lat0 != 0) begin
                lat0--;
                if (lat0 == 0) chk("r_lat0", resp0_valid, 1);
            end
            if (lat1 != 0) begin
                lat1--;
                if (lat1 == 0) chk("r_lat1", resp1_valid, 1);
            end
            if (resp0_valid && resp0_ready) begin
                chk("r_spur0", q0.size() != 0, 1);
                if (q0.size() != 0) chk("r_sb0", {resp0_flags, resp0_result}, q0.pop_front());
            end
            if (resp1_valid && resp1_ready) begin
                chk("r_spur1", q1.size() != 0, 1);
                if (q1.size() != 0) chk("r_sb1", {resp1_flags, resp1_result}, q1.pop_front());
            end
            e0 = req0_valid && (!resp0_valid || resp0_ready);
            e1 = req1_valid && (!resp1_valid || resp1_ready);
            if (prev_acc)      expg = 2'b00;
            else if (e0 && e1) expg = model_last ? 2'b01 : 2'b10;
            else               expg = {e1, e0};
            chk("r_arb", {req1_ready, req0_ready}, expg);
            acc0 = req0_valid && req0_ready;
            acc1 = req1_valid && req1_ready;
            if (acc0) begin
                q0.push_back(ref_op(req0_opcode, req0_shamt, req0_a, req0_b));
                lat0 = 2;
                model_last = 1'b0;
            end
            if (acc1) begin
                q1.push_back(ref_op(req1_opcode, req1_shamt, req1_a, req1_b));
                lat1 = 2;
                model_last = 1'b1;
            end
            prev_acc = acc0 || acc1;
            @(posedge clock); #1;
        end
        chk("r_q_empty", q0.size() + q1.size(), 0);
        chk("r_end_valid", {resp1_valid, resp0_valid}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
